// File: rtl/pwm_advanced_multiphase_bridge.sv
// N-phase half-bridge gate generator: double-buffered edge ticks, per-leg
// dead-time state machines and a latched fault that forces every gate low.
module pwm_advanced_multiphase_bridge #(
    parameter int bitwidth          = 8,
    parameter int phase_count       = 3,
    parameter int deadtime_bitwidth = 6
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [bitwidth-1:0]             counter_value,
    input  logic                            load_enable,
    input  logic [phase_count*bitwidth-1:0] tick_number_rising_edge,
    input  logic [phase_count*bitwidth-1:0] tick_number_falling_edge,
    input  logic [deadtime_bitwidth-1:0]    deadtime_ticks,
    input  logic [phase_count-1:0]          disable_output,
    input  logic                            fault,
    input  logic                            fault_clear,
    output logic [phase_count-1:0]          highside_output,
    output logic [phase_count-1:0]          lowside_output,
    output logic                            fault_latched,
    output logic                            load_pending
);

    localparam int TICK_W = phase_count * bitwidth;

    typedef enum logic [2:0] {
        LEG_OFF,
        LEG_HIGH,
        LEG_DT_TO_LOW,
        LEG_LOW,
        LEG_DT_TO_HIGH
    } leg_state_e;

    logic [TICK_W-1:0]            shadow_rise_q, shadow_rise_d;
    logic [TICK_W-1:0]            shadow_fall_q, shadow_fall_d;
    logic [TICK_W-1:0]            active_rise_q, active_rise_d;
    logic [TICK_W-1:0]            active_fall_q, active_fall_d;
    logic                         load_pending_q, load_pending_d;
    logic                         fault_latched_q, fault_latched_d;
    logic                         counter_zero;
    logic [deadtime_bitwidth-1:0] dt_load;

    assign counter_zero = (counter_value == '0);
    assign dt_load      = (deadtime_ticks == '0) ? deadtime_bitwidth'(1) : deadtime_ticks;

    // NOTE: every signal written here gets its hold value first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        shadow_rise_d  = shadow_rise_q;
        shadow_fall_d  = shadow_fall_q;
        active_rise_d  = active_rise_q;
        active_fall_d  = active_fall_q;
        load_pending_d = load_pending_q;
        if (load_enable) begin
            shadow_rise_d = tick_number_rising_edge;
            shadow_fall_d = tick_number_falling_edge;
            if (counter_zero) begin
                active_rise_d  = tick_number_rising_edge;
                active_fall_d  = tick_number_falling_edge;
                load_pending_d = 1'b0;
            end else begin
                load_pending_d = 1'b1;
            end
        end else if (counter_zero && load_pending_q) begin
            active_rise_d  = shadow_rise_q;
            active_fall_d  = shadow_fall_q;
            load_pending_d = 1'b0;
        end
    end

    // A simultaneous clear cannot release the latch while the fault persists.
    always_comb begin
        fault_latched_d = fault_latched_q;
        if (fault) begin
            fault_latched_d = 1'b1;
        end else if (fault_clear) begin
            fault_latched_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_rise_q   <= '0;
            shadow_fall_q   <= '0;
            active_rise_q   <= '0;
            active_fall_q   <= '0;
            load_pending_q  <= 1'b0;
            fault_latched_q <= 1'b0;
        end else begin
            shadow_rise_q   <= shadow_rise_d;
            shadow_fall_q   <= shadow_fall_d;
            active_rise_q   <= active_rise_d;
            active_fall_q   <= active_fall_d;
            load_pending_q  <= load_pending_d;
            fault_latched_q <= fault_latched_d;
        end
    end

    assign fault_latched = fault_latched_q;
    assign load_pending  = load_pending_q;

    for (genvar i = 0; i < phase_count; i++) begin : g_leg
        leg_state_e                   state_q, state_d;
        logic [deadtime_bitwidth-1:0] dt_q, dt_d;
        logic                         ref_q, ref_d;
        logic                         kill;
        logic [bitwidth-1:0]          rise_tick;
        logic [bitwidth-1:0]          fall_tick;

        // Compare against the next active set so a match at counter zero
        // already sees the values being adopted in that cycle.
        assign rise_tick = active_rise_d[i*bitwidth +: bitwidth];
        assign fall_tick = active_fall_d[i*bitwidth +: bitwidth];
        assign kill      = disable_output[i] | fault | fault_latched_q;

        always_comb begin
            ref_d = ref_q;
            if (counter_value == fall_tick) begin
                ref_d = 1'b0;
            end else if (counter_value == rise_tick) begin
                ref_d = 1'b1;
            end
        end

        always_comb begin
            state_d = state_q;
            dt_d    = dt_q;
            if (kill) begin
                state_d = LEG_OFF;
                dt_d    = '0;
            end else begin
                case (state_q)
                    LEG_OFF: begin
                        state_d = ref_q ? LEG_DT_TO_HIGH : LEG_DT_TO_LOW;
                        dt_d    = dt_load;
                    end
                    LEG_HIGH: begin
                        if (!ref_q) begin
                            state_d = LEG_DT_TO_LOW;
                            dt_d    = dt_load;
                        end
                    end
                    LEG_LOW: begin
                        if (ref_q) begin
                            state_d = LEG_DT_TO_HIGH;
                            dt_d    = dt_load;
                        end
                    end
                    // Reversing mid dead-time is safe: the opposite gate never turned on.
                    LEG_DT_TO_LOW: begin
                        if (ref_q) begin
                            state_d = LEG_HIGH;
                        end else if (dt_q <= deadtime_bitwidth'(1)) begin
                            state_d = LEG_LOW;
                        end else begin
                            dt_d = dt_q - deadtime_bitwidth'(1);
                        end
                    end
                    LEG_DT_TO_HIGH: begin
                        if (!ref_q) begin
                            state_d = LEG_LOW;
                        end else if (dt_q <= deadtime_bitwidth'(1)) begin
                            state_d = LEG_HIGH;
                        end else begin
                            dt_d = dt_q - deadtime_bitwidth'(1);
                        end
                    end
                    default: begin
                        state_d = LEG_OFF;
                        dt_d    = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                state_q <= LEG_OFF;
                dt_q    <= '0;
                ref_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                dt_q    <= dt_d;
                ref_q   <= ref_d;
            end
        end

        assign highside_output[i] = (state_q == LEG_HIGH);
        assign lowside_output[i]  = (state_q == LEG_LOW);
    end

endmodule

// File: tb/tb_pwm_advanced_multiphase_bridge.sv
// Self-checking bench for pwm_advanced_multiphase_bridge: a reset vector table,
// then free-running counter periods scored against edge-timing expectations.
module tb_pwm_advanced_multiphase_bridge;

    localparam int BW = 8;
    localparam int PH = 3;
    localparam int DW = 6;

    logic             clock = 1'b0;
    logic             reset;
    logic [BW-1:0]    counter_value;
    logic             load_enable;
    logic [PH*BW-1:0] tick_number_rising_edge;
    logic [PH*BW-1:0] tick_number_falling_edge;
    logic [DW-1:0]    deadtime_ticks;
    logic [PH-1:0]    disable_output;
    logic             fault;
    logic             fault_clear;
    logic [PH-1:0]    highside_output;
    logic [PH-1:0]    lowside_output;
    logic             fault_latched;
    logic             load_pending;

    always #5 clock = ~clock;

    pwm_advanced_multiphase_bridge #(
        .bitwidth          (BW),
        .phase_count       (PH),
        .deadtime_bitwidth (DW)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .counter_value            (counter_value),
        .load_enable              (load_enable),
        .tick_number_rising_edge  (tick_number_rising_edge),
        .tick_number_falling_edge (tick_number_falling_edge),
        .deadtime_ticks           (deadtime_ticks),
        .disable_output           (disable_output),
        .fault                    (fault),
        .fault_clear              (fault_clear),
        .highside_output          (highside_output),
        .lowside_output           (lowside_output),
        .fault_latched            (fault_latched),
        .load_pending             (load_pending)
    );

    typedef struct packed {
        logic [PH-1:0] h;
        logic [PH-1:0] l;
        logic          fl;
        logic          lp;
    } obs_t;

    typedef struct {
        string name;
        obs_t  exp;
    } sb_entry_t;

    typedef struct {
        logic          rst;
        logic [BW-1:0] cnt;
        obs_t          exp;
    } vec_t;

    sb_entry_t sb_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Expectation model: edge ticks in force, dead time, forced-off windows.
    int m_rise[PH];
    int m_fall[PH];
    int p_rise[PH];
    int p_fall[PH];
    int ev_rise[PH];
    int ev_fall[PH];
    bit m_pend;
    bit m_fl;
    int m_d;
    int off_lo[PH];
    int off_hi[PH];
    int ev_load_c;
    int ev_dis_c;
    int ev_fault_c;

    function automatic obs_t mk_obs(input logic [PH-1:0] h, input logic [PH-1:0] l,
                                    input logic fl, input logic lp);
        obs_t o;
        o.h  = h;
        o.l  = l;
        o.fl = fl;
        o.lp = lp;
        return o;
    endfunction

    // Gates seen after the edge that sampled counter c (sample index s).
    function automatic obs_t expect_for(input int c, input int s);
        obs_t o;
        o = mk_obs('0, '0, m_fl, m_pend);
        for (int i = 0; i < PH; i++) begin
            if (s >= off_lo[i] && s <= off_hi[i]) begin
                o.h[i] = 1'b0;
                o.l[i] = 1'b0;
            end else if (m_rise[i] == m_fall[i]) begin
                o.h[i] = 1'b0;
                o.l[i] = 1'b1;
            end else if (m_fall[i] - m_rise[i] < m_d) begin
                o.h[i] = 1'b0;
                o.l[i] = !(c >= m_rise[i] + 1 && c <= m_fall[i]);
            end else begin
                o.h[i] = (c >= m_rise[i] + 1 + m_d) && (c <= m_fall[i]);
                o.l[i] = (c <= m_rise[i]) || (c >= m_fall[i] + 1 + m_d);
            end
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected values are queued as the stimulus is driven, then scored once
    // the DUT has clocked it.
    task automatic cycle_check(input string name, input obs_t e);
        sb_entry_t ent;
        obs_t      got;
        ent.name = name;
        ent.exp  = e;
        sb_q.push_back(ent);
        @(posedge clock);
        #1;
        cyc++;
        got = mk_obs(highside_output, lowside_output, fault_latched, load_pending);
        ent = sb_q.pop_front();
        check($sformatf("%s cyc=%0d cnt=%0d {h,l,fl,lp}", ent.name, cyc, counter_value),
              32'(got), 32'(ent.exp));
        check($sformatf("no_shoot_through cyc=%0d", cyc),
              32'(highside_output & lowside_output), 32'd0);
    endtask

    task automatic step_count(input int c, input string name);
        counter_value  = BW'(c);
        load_enable    = 1'b0;
        disable_output = '0;
        fault          = 1'b0;
        fault_clear    = 1'b0;
        if (c == ev_load_c) begin
            load_enable = 1'b1;
            for (int i = 0; i < PH; i++) begin
                tick_number_rising_edge[i*BW +: BW]  = BW'(ev_rise[i]);
                tick_number_falling_edge[i*BW +: BW] = BW'(ev_fall[i]);
                p_rise[i] = ev_rise[i];
                p_fall[i] = ev_fall[i];
            end
            if (c == 0) begin
                m_rise = p_rise;
                m_fall = p_fall;
                m_pend = 1'b0;
            end else begin
                m_pend = 1'b1;
            end
        end else if (c == 0 && m_pend) begin
            m_rise = p_rise;
            m_fall = p_fall;
            m_pend = 1'b0;
        end
        if (c == ev_dis_c) begin
            disable_output = 3'b001;
            off_lo[0]      = cyc + 1;
            off_hi[0]      = cyc + 1 + m_d;
        end
        if (c == ev_fault_c) begin
            fault = 1'b1;
            m_fl  = 1'b1;
            for (int i = 0; i < PH; i++) begin
                off_lo[i] = cyc + 1;
                off_hi[i] = 1 << 30;
            end
        end else if (ev_fault_c >= 0 && c == ev_fault_c + 5) begin
            fault       = 1'b1;
            fault_clear = 1'b1;
        end else if (ev_fault_c >= 0 && c == ev_fault_c + 10) begin
            fault_clear = 1'b1;
            m_fl        = 1'b0;
            for (int i = 0; i < PH; i++) off_hi[i] = cyc + 1 + m_d;
        end
        cycle_check(name, expect_for(c, cyc + 1));
    endtask

    task automatic run_period(input string name);
        for (int c = 1; c < 256; c++) step_count(c, name);
    endtask

    task automatic set_load(input int c, input int r0, input int f0, input int r1,
                            input int f1, input int r2, input int f2);
        ev_load_c  = c;
        ev_rise[0] = r0;
        ev_fall[0] = f0;
        ev_rise[1] = r1;
        ev_fall[1] = f1;
        ev_rise[2] = r2;
        ev_fall[2] = f2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rst_tab[8];

        reset                    = 1'b1;
        counter_value            = '0;
        load_enable              = 1'b0;
        tick_number_rising_edge  = '0;
        tick_number_falling_edge = '0;
        deadtime_ticks           = DW'(4);
        disable_output           = '0;
        fault                    = 1'b0;
        fault_clear              = 1'b0;
        m_pend     = 1'b0;
        m_fl       = 1'b0;
        m_d        = 4;
        ev_load_c  = -1;
        ev_dis_c   = -1;
        ev_fault_c = -1;
        for (int i = 0; i < PH; i++) begin
            m_rise[i] = 0;
            m_fall[i] = 0;
            p_rise[i] = 0;
            p_fall[i] = 0;
            off_lo[i] = -1;
            off_hi[i] = -2;
        end

        // Reset release with 0/0 ticks and D=4: OFF -> DT_TO_LOW for four
        // cycles, lowside on the fifth edge after reset drops.
        rst_tab[0] = '{1'b1, 8'd0, mk_obs(3'b000, 3'b000, 1'b0, 1'b0)};
        rst_tab[1] = '{1'b1, 8'd0, mk_obs(3'b000, 3'b000, 1'b0, 1'b0)};
        rst_tab[2] = '{1'b0, 8'd0, mk_obs(3'b000, 3'b000, 1'b0, 1'b0)};
        rst_tab[3] = '{1'b0, 8'd0, mk_obs(3'b000, 3'b000, 1'b0, 1'b0)};
        rst_tab[4] = '{1'b0, 8'd0, mk_obs(3'b000, 3'b000, 1'b0, 1'b0)};
        rst_tab[5] = '{1'b0, 8'd0, mk_obs(3'b000, 3'b000, 1'b0, 1'b0)};
        rst_tab[6] = '{1'b0, 8'd0, mk_obs(3'b000, 3'b111, 1'b0, 1'b0)};
        rst_tab[7] = '{1'b0, 8'd0, mk_obs(3'b000, 3'b111, 1'b0, 1'b0)};
        for (int k = 0; k < 8; k++) begin
            reset         = rst_tab[k].rst;
            counter_value = rst_tab[k].cnt;
            cycle_check($sformatf("reset_vec%0d", k), rst_tab[k].exp);
        end

        // Load at count zero: adopted at once, load_pending never rises.
        set_load(0, 10, 100, 10, 100, 10, 100);
        step_count(0, "load_at_zero");

        // Period A: disable leg 0 at 40, stage leg 1 = 20/90 at count 50.
        set_load(50, 10, 100, 20, 90, 10, 100);
        ev_dis_c = 40;
        run_period("period_a");
        ev_load_c = -1;
        ev_dis_c  = -1;
        step_count(0, "wrap_adopt");

        // Period B: fault pulse while HIGH, clear blocked by fault, then clear.
        ev_fault_c = 40;
        run_period("period_b");
        ev_fault_c = -1;

        // Period C: deadtime 0 acts as 1; leg 2 has rising == falling.
        deadtime_ticks = '0;
        m_d            = 1;
        set_load(0, 10, 100, 20, 90, 30, 30);
        step_count(0, "load_dt0");
        ev_load_c = -1;
        run_period("period_c");

        // Period D: D=6 with leg 1 falling = rising+1 aborts its dead time.
        deadtime_ticks = DW'(6);
        m_d            = 6;
        set_load(0, 10, 100, 60, 61, 30, 30);
        step_count(0, "load_glitch");
        ev_load_c = -1;
        run_period("period_d");
        step_count(0, "final_wrap");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_advanced_multiphase_bridge.md
# pwm_advanced_multiphase_bridge

Parametrised N-phase bridge gate-signal generator: one high-side/low-side gate pair per phase, driven from a shared external counter. Per-phase edge tick numbers are double-buffered and adopted at counter zero. Each leg runs a state machine that enforces a programmable dead time between complementary gates. A latched fault input forces all gates low. The block sits between the PWM counter and the gate-driver pins of multi-phase converters and motor inverters.

## Interface
- bitwidth, 8, width of counter and tick numbers
- phase_count, 3, number of half-bridge legs (≥1)
- deadtime_bitwidth, 6, width of dead-time setting
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- counter_value  input  bitwidth  shared PWM counter
- load_enable  input  1  capture tick inputs into shadow registers
- tick_number_rising_edge  input  phase_count*bitwidth  phase i at [i*bitwidth +: bitwidth]; reference set point
- tick_number_falling_edge  input  phase_count*bitwidth  same packing; reference clear point
- deadtime_ticks  input  deadtime_bitwidth  dead time in clock cycles, used live, 0 treated as 1
- disable_output  input  phase_count  per-leg force-off
- fault  input  1  asynchronous-origin fault, sampled every clock
- fault_clear  input  1  clears fault latch
- highside_output  output  phase_count  high-side gates
- lowside_output  output  phase_count  low-side gates
- fault_latched  output  1  fault latch state
- load_pending  output  1  shadow holds values not yet active

## Operation
- Buffering: load_enable=1 -> shadow ← tick inputs, load_pending ← 1. When counter_value==0 and load_pending=1 -> active ← shadow, load_pending ← 0. If load_enable=1 and counter_value==0 in the same cycle, both active and shadow take the input values and load_pending stays 0.
- Reference per phase (registered): counter_value==active rising -> ref ← 1; counter_value==active falling -> ref ← 0. Falling wins when both match, so rising==falling gives a permanently low ref.
- Leg FSM per phase. Moore outputs: OFF (H=0,L=0), HIGH (1,0), DT_TO_LOW (0,0), LOW (0,1), DT_TO_HIGH (0,0).
- kill = disable_output[i] | fault | fault_latched. kill=1 -> OFF next cycle from any state. This has priority over all other transitions.
- OFF, kill=0: go to DT_TO_HIGH if ref=1, else DT_TO_LOW. Load the dt counter with max(deadtime_ticks,1).
- HIGH, ref=0: go to DT_TO_LOW and load the dt counter.
- LOW, ref=1: go to DT_TO_HIGH and load the dt counter.
- DT_TO_x: decrement the dt counter. When it equals 1, go to x.
- ref reverses during DT: DT_TO_LOW with ref=1 -> HIGH; DT_TO_HIGH with ref=0 -> LOW. This is safe because the opposite gate has not turned on.
- H and L of one leg are never both 1, in any state.
- Fault latch: fault=1 -> fault_latched ← 1. fault_clear=1 and fault=0 -> fault_latched ← 0. If fault and fault_clear are both 1, the latch stays set.
- Reset: all outputs 0, FSMs OFF, ref 0, shadow/active 0, dt counters 0, fault_latched 0, load_pending 0.

## Timing
- Counter match at cycle t -> ref changes at t+1 -> state/gate change at t+2.
- LOW->HIGH transition: lowside falls at t+2, highside rises at t+2+D, where D=max(deadtime_ticks,1). HIGH->LOW is symmetric.
- Kill or fault asserted at cycle t -> all affected gates 0 at t+1.
- Leaving OFF: at least D cycles with both gates low before either gate is driven high.
- Active tick update takes effect on the first counter_value==0 after capture. Matches at counter 0 use the new values.
- deadtime_ticks change takes effect at the next dt counter load. An in-flight dead time is not altered.

## Test plan
- Reset release, phase_count=3, D=4, ticks 0 rising/0 falling -> each leg OFF→DT_TO_LOW→LOW; lowside rises 5 cycles after reset deasserts; highside stays 0.
- Counter free-running 0..255, rising=10, falling=100, D=4 -> lowside falls 2 cycles after count 10, highside rises 4 cycles later. Mirror behaviour at count 100. Check H&L==0 every cycle.
- load_enable at count 50 with phase 1 rising=20 -> old values apply until count 0; load_pending=1 from cycle 51 until the wrap. Repeat with load_enable exactly at count 0 -> immediate adoption, load_pending stays 0.
- fault pulse one cycle while HIGH -> all gates 0 next cycle, fault_latched=1. fault_clear while fault high -> latch stays set. fault_clear with fault low -> leg re-enters via DT_TO_x, D cycles both low.
- deadtime_ticks=0 -> dead time of exactly 1 cycle. rising=falling=30 -> highside never asserts.
- Ref glitch: falling=rising+1 with D=6 -> DT_TO_HIGH aborts to LOW; highside never asserts and lowside is low for at most 3 cycles.
